mnist_fc_sequencer: RTL and testbench
=====================================

# mnist_fc_sequencer

Frame-level controller for a fully connected layer engine in the MNIST inference path. It streams one image (N_IN Q15 pixels) from a synchronous-read image buffer into the layer's load port and holds the layer's start line for the required window. It then captures the N_OUT neuron results into a result buffer and reports completion, a protocol error, or a watchdog timeout. One instance sits in front of each fully connected layer.

## Interface
- N_IN, 784: input vector length.
- N_OUT, 32: neurons produced per frame.
- TIMEOUT, 4096: maximum cycles allowed between successive result pulses in COMPUTE.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle request; accepted only in IDLE.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse on successful frame completion.
- error  out  1  sticky; cleared by reset or by an accepted frame_start.
- img_rd_en  out  1  image buffer read strobe.
- img_rd_addr  out  10  pixel address.
- img_rd_data  in  16  pixel data, valid exactly 1 cycle after img_rd_en.
- fc_start  out  1  layer start/load enable.
- fc_in_data  out  16  pixel to layer.
- fc_in_valid  out  1  pixel valid.
- fc_out_data  in  16  neuron result, Q15.
- fc_out_valid  in  1  one-cycle result pulse.
- fc_done  in  1  one-cycle layer completion pulse.
- res_wr_en  out  1  result buffer write.
- res_wr_addr  out  7  neuron index.
- res_wr_data  out  16  result word.

## Operation
- States: IDLE, LOAD, ARM, COMPUTE, DONE, ERR.
- IDLE:
  - frame_start=1 -> LOAD; clears error, read address, and result count.
  - fc_out_valid and fc_done are ignored.
- LOAD:
  - img_rd_en=1 with img_rd_addr = 0..N_IN-1 on consecutive cycles.
  - fc_in_valid mirrors img_rd_en delayed one cycle; fc_in_data = img_rd_data.
  - After issuing address N_IN-1 -> ARM.
- ARM: lasts exactly 2 cycles.
  - Cycle 1 carries the final fc_in_valid.
  - Cycle 2 has fc_start high with no valid, so the layer observes a full count.
  - Then -> COMPUTE.
- COMPUTE:
  - fc_start=0.
  - Each fc_out_valid writes the result at index res_cnt, then res_cnt increments.
  - fc_done with res_cnt (including a same-cycle write) == N_OUT -> DONE.
  - fc_done with a short count -> ERR.
  - fc_out_valid when res_cnt == N_OUT (overflow) -> ERR; the write is suppressed.
  - Watchdog counter clears on entry and on each fc_out_valid. Reaching TIMEOUT -> ERR.
- DONE: frame_done=1 for one cycle -> IDLE.
- ERR: error=1 (sticky), all strobes low -> IDLE next cycle.
- frame_start outside IDLE is ignored, with no queuing.
- Reset mid-frame: the next cycle has every output at its reset value and state IDLE. The layer is expected to be reset by the same signal.

## Timing
- Reset values: every output 0, state IDLE.
- frame_start sampled at edge 0:
  - LOAD occupies cycles 1..N_IN; fc_start rises in cycle 1.
  - fc_in_valid is high for cycles 2..N_IN+1, contiguous with no gaps.
  - fc_start stays high through cycle N_IN+2 and falls in cycle N_IN+3 (COMPUTE entry).
- Result write: res_wr_en, res_wr_addr, res_wr_data are registered and asserted the cycle after fc_out_valid.
- frame_done is asserted the cycle after the terminating fc_done. This is also the cycle of the last res_wr_en when the two coincide.
- Earliest accepted next frame_start: the cycle after frame_done.
- The watchdog is 13-bit saturating. Timeout fires exactly TIMEOUT cycles after the last clear.
- No arithmetic on data unless ReLU is enabled (see Configuration).

## Configuration
- FC_SEQ_RELU_EN defined:
  - res_wr_data = 0 when fc_out_data[15]=1, else fc_out_data.
  - The ReLU is a registered mux with no added latency.
- FC_SEQ_RELU_EN undefined: res_wr_data = fc_out_data unchanged.

## Test plan
- Nominal frame:
  - Stimulus: N_IN=784, N_OUT=32, buffer holds pixel[k]=k. Layer model emits 32 pulses with data 0x0100+n, then fc_done.
  - Required response: 784 contiguous fc_in_valid with data 0..783; fc_start high for 786 cycles; 32 writes at addresses 0..31; one frame_done; error=0.
- ReLU:
  - Stimulus: fc_out_data=0x8001 at neuron 5.
  - Required response: res_wr_data=0x0000 with FC_SEQ_RELU_EN defined; 0x8001 without it.
- Short frame:
  - Stimulus: fc_done after 31 results.
  - Required response: error=1 the next cycle, no frame_done, busy=0 after ERR.
- Timeout:
  - Stimulus: TIMEOUT=100, layer silent after 3 results.
  - Required response: error rises exactly 100 cycles after the third pulse. A subsequent frame_start clears error and the frame completes.
- Ignored requests:
  - Stimulus: frame_start pulsed during LOAD and COMPUTE; fc_out_valid pulsed in IDLE.
  - Required response: no restart, no res_wr_en.
- Reset mid-LOAD:
  - Stimulus: reset at address 400.
  - Required response: all outputs 0 next cycle. A fresh frame_start restarts from address 0 and completes.

Source files
------------

// File: rtl/mnist_fc_sequencer.sv
// Frame sequencer for one fully connected layer: streams an image in, arms the layer, collects results.
// Optional ReLU on captured results is enabled by defining FC_SEQ_RELU_EN.
module mnist_fc_sequencer #(
  parameter int N_IN    = 784,
  parameter int N_OUT   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  output logic        busy,
  output logic        frame_done,
  output logic        error,
  output logic        img_rd_en,
  output logic [9:0]  img_rd_addr,
  input  logic [15:0] img_rd_data,
  output logic        fc_start,
  output logic [15:0] fc_in_data,
  output logic        fc_in_valid,
  input  logic [15:0] fc_out_data,
  input  logic        fc_out_valid,
  input  logic        fc_done,
  output logic        res_wr_en,
  output logic [6:0]  res_wr_addr,
  output logic [15:0] res_wr_data
);

  localparam int          CNT_W     = $clog2(N_OUT + 1);
  localparam logic [9:0]  LAST_ADDR = 10'(N_IN - 1);
  localparam logic [CNT_W-1:0] N_OUT_C = CNT_W'(N_OUT);
  localparam logic [12:0] WD_LIMIT  = 13'(TIMEOUT - 1);
  localparam logic [12:0] WD_MAX    = 13'h1FFF;

  typedef enum logic [2:0] {IDLE, LOAD, ARM, COMPUTE, DONE, ERR} state_t;

  state_t             state_r;
  logic               arm_second_r;
  logic [CNT_W-1:0]   res_cnt_r;
  logic [12:0]        wd_r;

  logic               accept_s;
  logic               overflow_s;
  logic [CNT_W-1:0]   cnt_next_s;
  logic               timeout_s;
  logic               go_err_s;
  logic               go_done_s;

  function automatic logic [15:0] relu(input logic [15:0] d);
`ifdef FC_SEQ_RELU_EN
    relu = d[15] ? 16'h0000 : d;
`else
    relu = d;
`endif
  endfunction

  // Pixel data returns one cycle after the read, aligned with the delayed valid.
  assign fc_in_data = fc_in_valid ? img_rd_data : 16'h0000;

  // COMPUTE-state decisions: result acceptance, count check and watchdog expiry.
  always_comb begin
    accept_s   = fc_out_valid && (res_cnt_r != N_OUT_C);
    overflow_s = fc_out_valid && (res_cnt_r == N_OUT_C);
    cnt_next_s = accept_s ? (res_cnt_r + CNT_W'(1)) : res_cnt_r;
    timeout_s  = !fc_out_valid && (wd_r >= WD_LIMIT);
    go_err_s   = overflow_s || (fc_done && (cnt_next_s != N_OUT_C)) || timeout_s;
    go_done_s  = fc_done && !go_err_s;
  end

  // Frame FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      arm_second_r <= 1'b0;
      res_cnt_r    <= '0;
      wd_r         <= 13'd0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      error        <= 1'b0;
      img_rd_en    <= 1'b0;
      img_rd_addr  <= 10'd0;
      fc_start     <= 1'b0;
      fc_in_valid  <= 1'b0;
      res_wr_en    <= 1'b0;
      res_wr_addr  <= 7'd0;
      res_wr_data  <= 16'h0000;
    end else begin
      frame_done  <= 1'b0;
      res_wr_en   <= 1'b0;
      fc_in_valid <= img_rd_en;
      case (state_r)
        IDLE: begin
          if (frame_start) begin
            state_r     <= LOAD;
            busy        <= 1'b1;
            error       <= 1'b0;
            img_rd_en   <= 1'b1;
            img_rd_addr <= 10'd0;
            fc_start    <= 1'b1;
            res_cnt_r   <= '0;
          end else begin
            busy <= 1'b0;
          end
        end
        LOAD: begin
          if (img_rd_addr == LAST_ADDR) begin
            img_rd_en    <= 1'b0;
            img_rd_addr  <= 10'd0;
            arm_second_r <= 1'b0;
            state_r      <= ARM;
          end else begin
            img_rd_addr <= img_rd_addr + 10'd1;
          end
        end
        ARM: begin
          // Second ARM cycle keeps fc_start high with no valid so the layer sees the full count.
          if (arm_second_r) begin
            fc_start <= 1'b0;
            wd_r     <= 13'd1;
            state_r  <= COMPUTE;
          end else begin
            arm_second_r <= 1'b1;
          end
        end
        COMPUTE: begin
          if (fc_out_valid) begin
            wd_r <= 13'd1;
          end else if (wd_r == WD_MAX) begin
            wd_r <= wd_r;
          end else begin
            wd_r <= wd_r + 13'd1;
          end
          if (go_err_s) begin
            error   <= 1'b1;
            state_r <= ERR;
          end else begin
            res_wr_en <= accept_s;
            res_cnt_r <= cnt_next_s;
            if (accept_s) begin
              res_wr_addr <= 7'(res_cnt_r);
              res_wr_data <= relu(fc_out_data);
            end else begin
              res_wr_addr <= res_wr_addr;
            end
            if (go_done_s) begin
              frame_done <= 1'b1;
              state_r    <= DONE;
            end else begin
              state_r <= COMPUTE;
            end
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        ERR: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mnist_fc_sequencer.sv
// Scoreboard bench for mnist_fc_sequencer: directed frames, queued expectations, negedge monitor.
module tb_mnist_fc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        busy, frame_done, error, img_rd_en, fc_start, fc_in_valid, res_wr_en;
  logic [9:0]  img_rd_addr;
  logic [15:0] img_rd_data = 16'h0000;
  logic [15:0] fc_in_data, res_wr_data;
  logic [15:0] fc_out_data = 16'h0000;
  logic        fc_out_valid = 1'b0;
  logic        fc_done = 1'b0;
  logic [6:0]  res_wr_addr;

  always #5 clk = ~clk;

  mnist_fc_sequencer #(.N_IN(784), .N_OUT(32), .TIMEOUT(100)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .error(error), .img_rd_en(img_rd_en),
    .img_rd_addr(img_rd_addr), .img_rd_data(img_rd_data), .fc_start(fc_start),
    .fc_in_data(fc_in_data), .fc_in_valid(fc_in_valid), .fc_out_data(fc_out_data),
    .fc_out_valid(fc_out_valid), .fc_done(fc_done), .res_wr_en(res_wr_en),
    .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data)
  );

  // Image buffer model: pixel[k] = k, one-cycle read latency.
  always @(posedge clk) img_rd_data <= img_rd_en ? {6'd0, img_rd_addr} : 16'hDEAD;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] pix_q[$];
  logic [22:0] wr_q[$];
  int n_chk = 0, n_pass = 0;
  int n_valid, n_start, n_wr, n_done;
  int first_valid, last_valid, first_start, last_start, done_cyc, lastwr_cyc;

  function automatic logic [15:0] exp_res(input logic [15:0] d);
`ifdef FC_SEQ_RELU_EN
    return d[15] ? 16'h0000 : d;
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_counts();
    n_valid = 0; n_start = 0; n_wr = 0; n_done = 0;
    first_valid = -1; last_valid = -1; first_start = -1; last_start = -1;
    done_cyc = -1; lastwr_cyc = -1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a pixel or a result write.
  always @(negedge clk) begin
    if (!reset) begin
      if (fc_start) begin
        if (n_start == 0) first_start = cyc;
        last_start = cyc;
        n_start++;
      end
      if (fc_in_valid) begin
        if (n_valid == 0) first_valid = cyc;
        last_valid = cyc;
        n_valid++;
        if (pix_q.size() == 0) check("pixel_unexpected", 64'(fc_in_valid), 64'd0);
        else check("pixel_data", 64'(fc_in_data), 64'(pix_q.pop_front()));
      end
      if (res_wr_en) begin
        n_wr++;
        lastwr_cyc = cyc;
        if (wr_q.size() == 0) check("write_unexpected", 64'(res_wr_en), 64'd0);
        else check("result_write", 64'({res_wr_addr, res_wr_data}), 64'(wr_q.pop_front()));
      end
      if (frame_done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_frame(output int c0);
    clear_counts();
    tick();
    frame_start = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 784; k++) pix_q.push_back(16'(k));
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_compute();
    bit seen = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (fc_start) seen = 1'b1;
      else if (seen) break;
    end
    check("reach_compute", 64'(seen && !fc_start), 64'd1);
    tick();
  endtask

  // Layer model: n back-to-back results, optional odd value at one index, optional same-cycle done.
  task automatic emit(input int n, input int odd_idx, input logic [15:0] odd_val, input bit done_same);
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      d = (i == odd_idx) ? odd_val : (16'h0100 + 16'(i));
      fc_out_valid = 1'b1;
      fc_out_data  = d;
      wr_q.push_back({7'(i), exp_res(d)});
      if (done_same && i == n - 1) fc_done = 1'b1;
      tick();
      fc_out_valid = 1'b0;
      fc_done = 1'b0;
    end
  endtask

  task automatic frame_checks(input int c0, input int d);
    repeat (3) tick();
    check("start_cycles", 64'(n_start), 64'd786);
    check("start_first", 64'(first_start), 64'(c0 + 1));
    check("start_last", 64'(last_start), 64'(c0 + 786));
    check("valid_count", 64'(n_valid), 64'd784);
    check("valid_first", 64'(first_valid), 64'(c0 + 2));
    check("valid_last", 64'(last_valid), 64'(c0 + 785));
    check("pixels_left", 64'(pix_q.size()), 64'd0);
    check("write_count", 64'(n_wr), 64'd32);
    check("writes_left", 64'(wr_q.size()), 64'd0);
    check("done_count", 64'(n_done), 64'd1);
    check("done_cycle", 64'(done_cyc), 64'(d + 1));
    check("error_clear", 64'(error), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic full_frame_nominal();
    int c0, d;
    start_frame(c0);
    wait_compute();
    emit(32, -1, 16'h0000, 1'b0);
    fc_done = 1'b1;
    d = cyc;
    tick();
    fc_done = 1'b0;
    frame_checks(c0, d);
  endtask

  function automatic logic [55:0] all_outputs();
    return {busy, frame_done, error, img_rd_en, img_rd_addr, fc_start, fc_in_data,
            fc_in_valid, res_wr_en, res_wr_addr, res_wr_data};
  endfunction

  initial begin
    int c0, d, p, err_cyc;
    clear_counts();
    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs", 64'(all_outputs()), 64'd0);
    reset = 1'b0;
    tick();

    // Results offered while idle must be ignored.
    fc_out_valid = 1'b1; fc_out_data = 16'h1234; fc_done = 1'b1;
    tick();
    fc_out_valid = 1'b0; fc_done = 1'b0;
    repeat (2) tick();
    check("idle_no_write", 64'(n_wr), 64'd0);
    check("idle_not_busy", 64'(busy), 64'd0);

    // Nominal frame.
    full_frame_nominal();

    // ReLU value at neuron 5, done with the last result, ignored frame_start in LOAD and COMPUTE.
    start_frame(c0);
    repeat (100) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_compute();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    emit(32, 5, 16'h8001, 1'b1);
    d = cyc - 1;
    frame_checks(c0, d);
    check("done_with_last_write", 64'(lastwr_cyc), 64'(done_cyc));

    // Short frame: done after 31 results.
    start_frame(c0);
    wait_compute();
    emit(31, -1, 16'h0000, 1'b0);
    fc_done = 1'b1;
    tick();
    fc_done = 1'b0;
    @(negedge clk);
    check("short_error", 64'(error), 64'd1);
    check("short_busy_err", 64'(busy), 64'd1);
    @(negedge clk);
    check("short_busy_after", 64'(busy), 64'd0);
    check("short_error_sticky", 64'(error), 64'd1);
    check("short_no_done", 64'(n_done), 64'd0);
    check("short_writes", 64'(n_wr), 64'd31);

    // Timeout: layer silent after three results.
    start_frame(c0);
    @(negedge clk);
    check("error_cleared_on_start", 64'(error), 64'd0);
    wait_compute();
    emit(3, -1, 16'h0000, 1'b0);
    p = cyc - 1;
    err_cyc = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (error) begin
        err_cyc = cyc;
        break;
      end
    end
    check("timeout_cycle", 64'(err_cyc), 64'(p + 100));
    @(negedge clk);
    check("timeout_busy_after", 64'(busy), 64'd0);
    check("timeout_no_done", 64'(n_done), 64'd0);
    full_frame_nominal();

    // Reset in the middle of LOAD.
    start_frame(c0);
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (img_rd_en && img_rd_addr == 10'd400) break;
    end
    check("reached_addr_400", 64'({img_rd_en, img_rd_addr}), 64'({1'b1, 10'd400}));
    reset = 1'b1;
    @(negedge clk);
    check("midload_reset_outputs", 64'(all_outputs()), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    pix_q.delete();
    wr_q.delete();
    full_frame_nominal();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
